// File: rtl/frame_renderer_pkg.sv
// frame_renderer_pkg
// Shared definitions for the frame renderer and its pixel classifier:
// screen geometry, sprite sizes, colour constants, FSM state encoding, the
// per-frame game-state snapshot and a non-wrapping span test.
package frame_renderer_pkg;

  localparam int H_PIX   = 160;
  localparam int V_PIX   = 120;
  localparam int DUDE_SZ = 4;
  localparam int WALL_W  = 8;
  localparam int GAP_H   = 32;

  localparam logic [2:0] BG_COLOUR  = 3'b000;
  localparam logic [2:0] WALL_COL   = 3'b010;
  localparam logic [2:0] DUDE_COL   = 3'b111;
  localparam logic [2:0] MENU_COL   = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Game state captured when a frame is accepted; the whole frame renders
  // from this copy so mid-frame input changes cannot tear the image.
  typedef struct packed {
    logic       game;    // 1 = game frame, 0 = menu frame
    logic [7:0] dude_x;
    logic [6:0] dude_y;
    logic [7:0] wall_x;
    logic [6:0] gap_y;
  } snap_t;

  // lo <= v < lo+len, evaluated in 9 bits so an extent running past the
  // screen edge is clipped instead of wrapping around to column/row 0.
  function automatic logic in_span(input logic [8:0] v,
                                   input logic [8:0] lo,
                                   input logic [8:0] len);
    logic [8:0] hi;
    hi = lo + len;
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/frame_renderer_pixel_classify.sv
// render_pixel_classify
// Purely combinational pixel classifier: given a screen coordinate and a
// game-state snapshot, returns the pixel colour plus raw dude/wall hit flags.
// Ports:
//   x, y      in   pixel coordinate
//   snap      in   game-state snapshot
//   colour    out  pixel colour (menu > dude > wall > background)
//   dude_hit  out  pixel lies inside the dude square
//   wall_hit  out  pixel lies on the wall outside the gap
// Hit flags are geometric only; the caller masks them for menu frames.
module render_pixel_classify
  import frame_renderer_pkg::*;
(
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  snap_t      snap,
  output logic [2:0] colour,
  output logic       dude_hit,
  output logic       wall_hit
);

  logic [8:0] x9, y9;
  logic       in_gap;

  assign x9 = {1'b0, x};
  assign y9 = {2'b00, y};

  always_comb begin
    dude_hit = in_span(x9, {1'b0, snap.dude_x}, 9'(DUDE_SZ)) &&
               in_span(y9, {2'b00, snap.dude_y}, 9'(DUDE_SZ));
    // wall_x >= H_PIX can never satisfy the lower bound, so an off-screen
    // wall needs no special case.
    in_gap   = in_span(y9, {2'b00, snap.gap_y}, 9'(GAP_H));
    wall_hit = in_span(x9, {1'b0, snap.wall_x}, 9'(WALL_W)) && !in_gap;

    if (!snap.game)    colour = MENU_COL;
    else if (dude_hit) colour = DUDE_COL;
    else if (wall_hit) colour = WALL_COL;
    else               colour = BG_COLOUR;
  end

endmodule

// File: rtl/frame_renderer.sv
// frame_renderer
// Rasterises one snapshot of game state (dude, wall) into per-pixel VGA
// writes, one pixel per clock, x fastest, and reports dude/wall overlap.
// Ports:
//   clk, reset              clock, async active-high reset
//   start_frame             pulse: render one frame (ignored unless idle)
//   startgame               1 = game frame, 0 = menu fill
//   dude_x/dude_y           dude top-left
//   wall_x, gap_y           wall left column, gap top row
//   vga_x/vga_y/vga_colour  pixel write, valid while vga_plot is high
//   busy                    high on every plot cycle of a frame
//   frame_done              one-cycle pulse after the last plot
//   collision               overlap result of the last frame (0 for menu)
module frame_renderer
  import frame_renderer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start_frame,
  input  logic       startgame,
  input  logic [7:0] dude_x,
  input  logic [6:0] dude_y,
  input  logic [7:0] wall_x,
  input  logic [6:0] gap_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       frame_done,
  output logic       collision
);

  state_t     state;
  snap_t      snap;
  logic [7:0] x;
  logic [6:0] y;
  logic       acc;

  logic [2:0] pix_colour;
  logic       dude_hit, wall_hit;

  render_pixel_classify u_classify (
    .x        (x),
    .y        (y),
    .snap     (snap),
    .colour   (pix_colour),
    .dude_hit (dude_hit),
    .wall_hit (wall_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      snap       <= '0;
      x          <= '0;
      y          <= '0;
      acc        <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      collision  <= 1'b0;
    end else begin
      // Strobes default low; vga_x/y/colour hold outside SCAN.
      vga_plot   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_frame) begin
            snap  <= '{game:   startgame,
                       dude_x: dude_x,
                       dude_y: dude_y,
                       wall_x: wall_x,
                       gap_y:  gap_y};
            x     <= '0;
            y     <= '0;
            acc   <= 1'b0;
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          vga_x      <= x;
          vga_y      <= y;
          vga_colour <= pix_colour;
          vga_plot   <= 1'b1;
          // busy is registered with the plot so it covers exactly the
          // plot cycles of the frame.
          busy       <= 1'b1;
          acc        <= acc | (snap.game & dude_hit & wall_hit);
          if (x == 8'(H_PIX - 1)) begin
            x <= '0;
            if (y == 7'(V_PIX - 1)) state <= ST_DONE;
            else                    y     <= y + 7'd1;
          end else begin
            x <= x + 8'd1;
          end
        end
        ST_DONE: begin
          frame_done <= 1'b1;
          collision  <= acc;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
